// File: rtl/data_memory_arbiter_pkg.sv
// Shared definitions for the two-port data memory arbiter: FSM encodings,
// default widths and requester identifiers.
package data_memory_arbiter_pkg;

  localparam int ADDR_WIDTH = 6;
  localparam int DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RESPOND = 2'd2
  } arbState_t;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/data_memory_arbiter_rr_arbiter2.sv
// Two-way round-robin grant: a lone valid requester wins, a tie goes to the
// requester that did not win last time. Purely combinational.
module rr_arbiter2
  import data_memory_arbiter_pkg::*;
(
  input  logic valid0,
  input  logic valid1,
  input  logic lastGrant,
  input  logic enable,
  output logic grantIdx,
  output logic grantValid
);

  always_comb begin
    grantValid = enable && (valid0 || valid1);
    if (valid0 && valid1) begin
      grantIdx = ~lastGrant;
    end else if (valid1) begin
      grantIdx = PORT1;
    end else begin
      grantIdx = PORT0;
    end
  end

endmodule

// File: rtl/data_memory_arbiter.sv
// Arbitrates the single-port data memory between the core (port 0) and the
// debug/DMA loader (port 1); each access runs IDLE -> ACCESS -> RESPOND.
module data_memory_arbiter
  import data_memory_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = data_memory_arbiter_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = data_memory_arbiter_pkg::DATA_WIDTH
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  req0_valid,
  input  logic                  req0_write,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_wdata,
  output logic                  req0_ready,
  output logic                  rsp0_valid,
  output logic [DATA_WIDTH-1:0] rsp0_rdata,
  input  logic                  req1_valid,
  input  logic                  req1_write,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_wdata,
  output logic                  req1_ready,
  output logic                  rsp1_valid,
  output logic [DATA_WIDTH-1:0] rsp1_rdata,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  output logic                  mem_read,
  output logic                  mem_write,
  input  logic [DATA_WIDTH-1:0] mem_read_data,
  output logic                  busy
);

  arbState_t stateReg, stateNext;
  logic      lastGrantReg;
  logic      ownerReg;
  logic      writeReg;
  logic      rsp0ValidReg, rsp1ValidReg;
  logic      grantIdx, grantValid;
  logic      arbEnable;

  logic                  selWrite;
  logic [ADDR_WIDTH-1:0] selAddr;
  logic [DATA_WIDTH-1:0] selWdata;

  // Ready is held low while Reset is asserted so nothing is accepted in reset.
  assign arbEnable = (stateReg == IDLE) && !Reset;

  rr_arbiter2 uArbiter (
    .valid0     (req0_valid),
    .valid1     (req1_valid),
    .lastGrant  (lastGrantReg),
    .enable     (arbEnable),
    .grantIdx   (grantIdx),
    .grantValid (grantValid)
  );

  assign selWrite = (grantIdx == PORT1) ? req1_write : req0_write;
  assign selAddr  = (grantIdx == PORT1) ? req1_addr  : req0_addr;
  assign selWdata = (grantIdx == PORT1) ? req1_wdata : req0_wdata;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      stateReg <= IDLE;
    end else begin
      stateReg <= stateNext;
    end
  end

  always_comb begin
    stateNext = stateReg;
    case (stateReg)
      IDLE:    if (grantValid) stateNext = ACCESS;
      ACCESS:  stateNext = RESPOND;
      RESPOND: stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    busy       = (stateReg != IDLE);
    req0_ready = grantValid && (grantIdx == PORT0);
    req1_ready = grantValid && (grantIdx == PORT1);
    rsp0_valid = rsp0ValidReg;
    rsp1_valid = rsp1ValidReg;
    rsp0_rdata = (rsp0ValidReg && !writeReg) ? mem_read_data : '0;
    rsp1_rdata = (rsp1ValidReg && !writeReg) ? mem_read_data : '0;
  end

  // mem_address / mem_write_data double as the latched request address and data.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      lastGrantReg   <= PORT1;
      ownerReg       <= PORT0;
      writeReg       <= 1'b0;
      mem_address    <= '0;
      mem_write_data <= '0;
      mem_read       <= 1'b0;
      mem_write      <= 1'b0;
      rsp0ValidReg   <= 1'b0;
      rsp1ValidReg   <= 1'b0;
    end else begin
      mem_read     <= 1'b0;
      mem_write    <= 1'b0;
      rsp0ValidReg <= 1'b0;
      rsp1ValidReg <= 1'b0;
      if (grantValid) begin
        lastGrantReg   <= grantIdx;
        ownerReg       <= grantIdx;
        writeReg       <= selWrite;
        mem_address    <= selAddr;
        mem_write_data <= selWdata;
        mem_read       <= ~selWrite;
        mem_write      <= selWrite;
      end
      if (stateReg == ACCESS) begin
        rsp0ValidReg <= (ownerReg == PORT0);
        rsp1ValidReg <= (ownerReg == PORT1);
      end
    end
  end

endmodule
